// File: rtl/timer_multi.sv
// Multi-channel interval timer on an Avalon-MM slave. It has NUM_CH independent
// down-counters with a programmable period, one-shot or continuous mode, snapshot capture and per-channel IRQs.
module timer_multi #(
  parameter int NUM_CH       = 2,
  parameter int WIDTH        = 24,
  parameter int RESET_PERIOD = 2499,
  parameter int ADDR_W       = 3 + (($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [15:0]       writedata,
  output logic [15:0]       readdata,
  output logic [NUM_CH-1:0] irq_ch,
  output logic              irq
);

  localparam logic [WIDTH-1:0] RST_PERIOD = WIDTH'(RESET_PERIOD);
  localparam int CH_W = ADDR_W - 3;

  logic [WIDTH-1:0]  period_q [NUM_CH];
  logic [WIDTH-1:0]  period_d [NUM_CH];
  logic [WIDTH-1:0]  count_q  [NUM_CH];
  logic [WIDTH-1:0]  count_d  [NUM_CH];
  logic [WIDTH-1:0]  snap_q   [NUM_CH];
  logic [WIDTH-1:0]  snap_d   [NUM_CH];
  logic [3:0]        ctrl_q   [NUM_CH];
  logic [3:0]        ctrl_d   [NUM_CH];
  logic [NUM_CH-1:0] to_q, to_d;
  logic [NUM_CH-1:0] run_q, run_d;
  logic [NUM_CH-1:0] reload_q, reload_d;
  logic [15:0]       readdata_q, readdata_d;

  logic            wr;
  logic [2:0]      regSel;
  logic [CH_W-1:0] chSel;
  logic            hit;
  logic            expire;
  logic            start;
  logic            stop;
  logic [31:0]     perExt;
  logic [31:0]     snapExt;

  assign wr     = chipselect & ~write_n;
  assign regSel = address[2:0];
  assign chSel  = address[ADDR_W-1:3];

  // Channel indices at or above NUM_CH never match a loop index, so they read 0 and ignore writes.
  always_comb begin
    hit        = 1'b0;
    expire     = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    perExt     = '0;
    snapExt    = '0;
    readdata_d = '0;
    to_d       = to_q;
    run_d      = run_q;
    reload_d   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      period_d[i] = period_q[i];
      count_d[i]  = count_q[i];
      snap_d[i]   = snap_q[i];
      ctrl_d[i]   = ctrl_q[i];
      perExt      = 32'(period_q[i]);
      snapExt     = 32'(snap_q[i]);
      hit         = wr && (int'(chSel) == i);
      expire      = run_q[i] && (count_q[i] == '0);
      start       = hit && (regSel == 3'd1) && writedata[2];
      stop        = hit && (regSel == 3'd1) && writedata[3];

      // A pending forced reload overrides both counting and a coincident expiry.
      if (reload_q[i]) begin
        count_d[i] = period_q[i];
      end else if (expire) begin
        count_d[i] = period_q[i];
        to_d[i]    = 1'b1;
      end else if (run_q[i]) begin
        count_d[i] = count_q[i] - WIDTH'(1);
      end

      if (hit) begin
        case (regSel)
          3'd0: to_d[i] = 1'b0;
          3'd1: ctrl_d[i] = writedata[3:0];
          3'd2: begin
            period_d[i] = WIDTH'({perExt[31:16], writedata});
            reload_d[i] = 1'b1;
          end
          3'd3: begin
            period_d[i] = WIDTH'({writedata, perExt[15:0]});
            reload_d[i] = (WIDTH > 16);
          end
          3'd4, 3'd5: snap_d[i] = count_q[i];
          default: ;
        endcase
      end

      if (start) begin
        run_d[i] = 1'b1;
      end else if (stop || reload_q[i] || (expire && !ctrl_q[i][1])) begin
        run_d[i] = 1'b0;
      end

      if (int'(chSel) == i) begin
        case (regSel)
          3'd0: readdata_d = {14'd0, run_q[i], to_q[i]};
          3'd1: readdata_d = {12'd0, ctrl_q[i]};
          3'd2: readdata_d = perExt[15:0];
          3'd3: readdata_d = perExt[31:16];
          3'd4: readdata_d = snapExt[15:0];
          3'd5: readdata_d = snapExt[31:16];
          default: readdata_d = '0;
        endcase
      end
    end
  end

  always_comb begin
    irq_ch = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      irq_ch[i] = to_q[i] & ctrl_q[i][0];
    end
  end

  assign irq      = |irq_ch;
  assign readdata = readdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        period_q[i] <= RST_PERIOD;
        count_q[i]  <= RST_PERIOD;
        snap_q[i]   <= '0;
        ctrl_q[i]   <= '0;
      end
      to_q       <= '0;
      run_q      <= '0;
      reload_q   <= '0;
      readdata_q <= '0;
    end else begin
      period_q   <= period_d;
      count_q    <= count_d;
      snap_q     <= snap_d;
      ctrl_q     <= ctrl_d;
      to_q       <= to_d;
      run_q      <= run_d;
      reload_q   <= reload_d;
      readdata_q <= readdata_d;
    end
  end

endmodule

// File: tb/tb_timer_multi.sv
// Scoreboard bench for timer_multi. Stimulus queues the expected readdata/irq, and a
// monitor compares them one cycle later. NUM_CH=3 so that channel index NUM_CH is addressable.
module tb_timer_multi;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = '0;
  logic [15:0] readdata;
  logic [2:0]  irq_ch;
  logic        irq;

  typedef struct {
    string       name;
    bit          chkRd;
    logic [15:0] expRd;
    bit          chkIrq;
    logic [3:0]  expIrq;
  } sbEntry_t;

  sbEntry_t expQ[$];
  bit opValid = 1'b0;
  bit stagePending = 1'b0;
  int errors = 0;
  int checks = 0;

  timer_multi #(
    .NUM_CH(3),
    .WIDTH(24),
    .RESET_PERIOD(2499)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .irq_ch(irq_ch),
    .irq(irq)
  );

  always #5 clk = ~clk;

  // Each op drives one cycle's bus inputs on the falling edge and optionally queues an expectation.
  task automatic applyStimulus(input bit doWr, input int ch, input int rg, input logic [15:0] wdata,
                               input bit chkRd, input logic [15:0] expRd,
                               input bit chkIrq, input logic [3:0] expIrq, input string name);
    sbEntry_t e;
    @(negedge clk);
    address    = 5'(ch * 8 + rg);
    chipselect = 1'b1;
    write_n    = !doWr;
    writedata  = wdata;
    opValid    = chkRd || chkIrq;
    if (opValid) begin
      e.name   = name;
      e.chkRd  = chkRd;
      e.expRd  = expRd;
      e.chkIrq = chkIrq;
      e.expIrq = expIrq;
      expQ.push_back(e);
    end
  endtask

  task automatic setReset(input bit v);
    @(negedge clk);
    reset      = v;
    chipselect = 1'b0;
    write_n    = 1'b1;
    opValid    = 1'b0;
  endtask

  task automatic wrReg(input int ch, input int rg, input logic [15:0] d);
    applyStimulus(1'b1, ch, rg, d, 1'b0, '0, 1'b0, '0, "wr");
  endtask

  task automatic wrIrq(input int ch, input int rg, input logic [15:0] d, input logic [3:0] expIrq, input string name);
    applyStimulus(1'b1, ch, rg, d, 1'b0, '0, 1'b1, expIrq, name);
  endtask

  task automatic rdReg(input int ch, input int rg, input logic [15:0] expRd, input string name);
    applyStimulus(1'b0, ch, rg, '0, 1'b1, expRd, 1'b0, '0, name);
  endtask

  task automatic rdIrq(input int ch, input int rg, input logic [15:0] expRd, input logic [3:0] expIrq, input string name);
    applyStimulus(1'b0, ch, rg, '0, 1'b1, expRd, 1'b1, expIrq, name);
  endtask

  // Reading unused register 6 of ch0 also exercises its always-zero decode.
  task automatic irqChk(input logic [3:0] expIrq, input string name);
    applyStimulus(1'b0, 0, 6, '0, 1'b1, 16'h0000, 1'b1, expIrq, name);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 0, 6, '0, 1'b0, '0, 1'b0, '0, "idle");
  endtask

  task automatic checkOutput();
    sbEntry_t e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_output: scoreboard empty, readdata=%h irq=%b", readdata, {irq, irq_ch});
      return;
    end
    e = expQ.pop_front();
    if (e.chkRd) begin
      checks++;
      if (readdata !== e.expRd) begin
        errors++;
        $display("[TB] FAIL %s readdata actual=%h required=%h", e.name, readdata, e.expRd);
      end
    end
    if (e.chkIrq) begin
      checks++;
      if ({irq, irq_ch} !== e.expIrq) begin
        errors++;
        $display("[TB] FAIL %s {irq,irq_ch} actual=%b required=%b", e.name, {irq, irq_ch}, e.expIrq);
      end
    end
  endtask

  always @(posedge clk) stagePending <= opValid;

  always @(negedge clk) if (stagePending) checkOutput();

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset: readdata is cleared even while addressing PERIOD_L
    idle(1);
    rdIrq(0, 2, 16'h0000, 4'b0000, "rst_readdata");
    setReset(1'b0);
    rdReg(0, 2, 16'h09C3, "rst_period_l");
    rdReg(0, 0, 16'h0000, "rst_status");
    rdReg(0, 1, 16'h0000, "rst_control");
    rdReg(2, 3, 16'h0000, "rst_period_h");
    rdReg(0, 4, 16'h0000, "rst_snap_l");

    // One-shot on ch1, period 9, START on the force-reload edge
    wrReg(1, 2, 16'd9);
    wrReg(1, 1, 16'h0005);
    rdReg(1, 0, 16'h0002, "os_running");
    idle(7);
    irqChk(4'b0000, "os_before_to");
    rdIrq(1, 0, 16'h0002, 4'b1010, "os_timeout");
    rdIrq(1, 0, 16'h0001, 4'b1010, "os_stopped");
    wrIrq(1, 0, 16'h0000, 4'b0000, "os_clear");
    wrReg(1, 4, 16'h0000);
    rdReg(1, 4, 16'd9, "os_reloaded_count");

    // Continuous on ch0, period 3
    wrReg(0, 2, 16'd3);
    wrReg(0, 1, 16'h0007);
    idle(2);
    irqChk(4'b0000, "cont_count0");
    irqChk(4'b1001, "cont_to1");
    wrIrq(0, 0, 16'h0000, 4'b0000, "cont_clr1");
    idle(1);
    irqChk(4'b0000, "cont_pre_to2");
    irqChk(4'b1001, "cont_to2");
    wrReg(0, 0, 16'h0000);
    idle(2);
    wrIrq(0, 0, 16'h0000, 4'b0000, "cont_clear_beats_to");
    rdReg(0, 0, 16'h0002, "cont_status_after_clr");
    idle(2);
    irqChk(4'b1001, "cont_to4");
    wrIrq(0, 1, 16'h0008, 4'b0000, "cont_stop_ito_off");
    rdReg(0, 0, 16'h0001, "cont_stopped_status");
    wrReg(0, 0, 16'h0000);

    // Width split on ch2
    wrReg(2, 3, 16'h0012);
    wrReg(2, 2, 16'h3456);
    rdReg(2, 3, 16'h0012, "ws_period_h");
    rdReg(2, 2, 16'h3456, "ws_period_l");
    wrReg(2, 4, 16'h0000);
    rdReg(2, 5, 16'h0012, "ws_snap_h");
    rdReg(2, 4, 16'h3456, "ws_snap_l");
    wrReg(2, 3, 16'hFFFF);
    rdReg(2, 3, 16'h00FF, "ws_period_h_trunc");
    rdReg(2, 0, 16'h0000, "ws_status_idle");
    wrReg(2, 1, 16'h0004);
    rdReg(2, 0, 16'h0002, "ws_running");
    wrReg(2, 2, 16'h0005);
    rdReg(2, 0, 16'h0002, "ws_run_before_reload");
    rdReg(2, 0, 16'h0000, "ws_run_cleared");
    wrReg(2, 4, 16'h0000);
    rdReg(2, 4, 16'h0005, "ws_reload_l");
    rdReg(2, 5, 16'h00FF, "ws_reload_h");

    // Snapshot while ch0 runs from period 100
    wrReg(0, 2, 16'd100);
    wrReg(0, 1, 16'h0006);
    idle(3);
    wrReg(0, 4, 16'h0000);
    rdReg(0, 4, 16'd97, "snap_first");
    rdReg(0, 5, 16'h0000, "snap_first_h");
    wrReg(0, 5, 16'h0000);
    rdReg(0, 4, 16'd94, "snap_second");
    wrReg(0, 1, 16'h0008);

    // START beats STOP in the same write
    wrReg(1, 1, 16'h000C);
    rdReg(1, 0, 16'h0002, "prio_start_wins");
    rdReg(1, 1, 16'h000C, "prio_control");
    wrReg(1, 1, 16'h0008);
    rdReg(1, 0, 16'h0000, "prio_stopped");

    // Channel index NUM_CH is decoded as absent
    wrReg(3, 2, 16'h1111);
    wrReg(3, 1, 16'h0005);
    rdReg(3, 2, 16'h0000, "dec_period_l");
    rdIrq(3, 0, 16'h0000, 4'b0000, "dec_status");
    rdReg(1, 2, 16'd9, "dec_no_alias_period");
    rdReg(1, 1, 16'h0008, "dec_no_alias_ctrl");
    rdReg(3, 1, 16'h0000, "dec_ctrl");
    rdReg(0, 7, 16'h0000, "dec_reg7");

    // Reset in the middle of a count
    wrReg(0, 1, 16'h0007);
    idle(1);
    setReset(1'b1);
    setReset(1'b0);
    rdReg(0, 2, 16'h09C3, "mid_rst_period");
    rdIrq(0, 0, 16'h0000, 4'b0000, "mid_rst_status");
    rdReg(0, 1, 16'h0000, "mid_rst_ctrl");
    rdReg(2, 3, 16'h0000, "mid_rst_period_h");
    rdReg(0, 4, 16'h0000, "mid_rst_snap");

    idle(3);
    @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_multi.md
# timer_multi

Parametrised multi-channel interval timer on an Avalon-MM slave, the successor to the per-processor fixed-period system timer. It provides NUM_CH independent down-counters with software-programmable period, one-shot or continuous mode, snapshot capture and per-channel interrupts. Each processor subsystem uses one instance for tick generation and code profiling.

## Interface
- NUM_CH, 2: number of timer channels, 1..8.
- WIDTH, 24: counter and period width in bits, 8..32.
- RESET_PERIOD, 2499: period value loaded at reset into every channel. Must fit in WIDTH.
- ADDR_W, derived: 3 + max(1, clog2(NUM_CH)).
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- address  in  ADDR_W  word address. Bits [2:0] select the register; the upper bits select the channel.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  16  write data.
- readdata  out  16  registered read data.
- irq_ch  out  NUM_CH  per-channel interrupt.
- irq  out  1  OR of irq_ch.

## Operation
- Write strobe wr = chipselect & ~write_n. Reads need no strobe: readdata follows the address every cycle.
- Per-channel register map (reg = address[2:0]):
  - 0 STATUS: bit0 TO, bit1 RUN. Any write clears TO.
  - 1 CONTROL: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP.
    - Writing stores bits [3:0].
    - START and STOP are also one-cycle strobes taken from writedata.
  - 2 PERIOD_L: period[15:0].
  - 3 PERIOD_H: period[WIDTH-1:16]. If WIDTH<=16, reads return 0 and writes are ignored.
  - 4 SNAP_L and 5 SNAP_H: snapshot[15:0] and snapshot[WIDTH-1:16].
    - A write to either one copies the live counter into the snapshot register.
  - 6 and 7: read 0, writes ignored.
- A channel index >= NUM_CH reads 0 and ignores writes.
- Counter behaviour while RUN=1:
  - Counter != 0: decrements by 1.
  - Counter == 0: reloads the period and sets TO. If CONT=0, RUN clears in the same cycle.
  - The timeout interval is therefore period+1 cycles. period=0 gives a timeout every cycle in continuous mode.
- A PERIOD_L or PERIOD_H write:
  - updates that half of the period immediately;
  - the next cycle, forces a counter reload from the new period and clears RUN (force_reload).
- RUN priority: START > (STOP | force_reload | one-shot expiry).
- TO priority: a STATUS write clear beats a same-cycle timeout.
- irq_ch[i] = TO[i] & ITO[i], combinational from registers. irq = |irq_ch.
- Read widths: undefined upper bits read 0, and bits above WIDTH-1 read 0.

## Timing
- Reset (synchronous) sets:
  - period = counter = RESET_PERIOD;
  - snapshot = 0, CONTROL = 0, TO = 0, RUN = 0;
  - readdata = 0, irq_ch = 0, irq = 0.
- Read latency is 1 cycle: readdata in cycle N+1 reflects the address and register state at edge N.
- START written at edge N: RUN=1 after edge N; the first decrement happens at edge N+1.
- Counter reaches 0 at edge M with RUN=1: the reload and TO=1 take effect after edge M+1, and irq rises in that cycle.
- Snapshot captures the counter value that is present before edge N, where N is the write edge.
- Period write at edge N: force_reload=1 after edge N; counter=period and RUN=0 after edge N+1.
  - A START written at edge N+1 still sets RUN.
- Reset mid-count: all state returns to reset values at the next edge. Stale reads and interrupts are discarded.
- Channels are fully independent; simultaneous timeouts on several channels are all captured.

## Test plan
- Reset: assert reset for 2 cycles -> readdata=0 and irq=0; read ch0 PERIOD_L returns 0x09C3; STATUS returns 0.
- One-shot: write period 9 to ch1, then CONTROL=0x5 (START|ITO) -> after 10 decrement cycles TO=1, RUN=0, irq_ch=2'b10 and irq=1; a STATUS write clears irq the next cycle.
- Continuous: period 3, CONTROL=0x7 -> TO pulses every 4 cycles; a STATUS clear issued on the same edge as a timeout leaves TO=0.
- Width split: WIDTH=24, write PERIOD_H=0x12 and PERIOD_L=0x3456 -> PERIOD_H reads 0x0012; writing 0xFFFF to PERIOD_H reads back 0x00FF; the counter reloads 0x123456 and RUN=0.
- Snapshot: ch0 running from period 100; write SNAP_L at edge N -> SNAP_L/SNAP_H return the pre-edge counter value, and the counter keeps running.
- Priority and decode:
  - CONTROL=0xC (START|STOP) -> RUN=1.
  - Writing to channel index NUM_CH has no effect and reads return 0.
